// File: rtl/parallel_lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to a 4-bit-per-beat LFSR
// stream, tracks lock and counts errored beats and bits while locked.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   ready, data[3:0]   beat qualifier and nibble (data[3] earliest bit)
//   clr_cnt            synchronous clear of both error counters
//   locked             FSM is in LOCKED
//   err_pulse          one-cycle pulse per errored beat while locked
//   beat_err_cnt       saturating count of errored beats while locked
//   bit_err_cnt        saturating count of mismatched bits while locked
module parallel_lfsr_checker #(
    parameter int               LFSR_W     = 7,
    parameter logic [LFSR_W-1:0] TAPS      = 7'h60,
    parameter int               LOCK_BEATS = 4,
    parameter int               LOSS_BEATS = 3,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ready,
    input  logic [3:0]       data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] beat_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int FILL_BEATS = (LFSR_W + 3) / 4;
    localparam int FILL_W     = $clog2(FILL_BEATS + 1);
    localparam int GOOD_W     = $clog2(LOCK_BEATS + 1);
    localparam int BAD_W      = $clog2(LOSS_BEATS + 1);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_BEATS);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_BEATS);
    localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(LOSS_BEATS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]        state, state_n;
    logic [LFSR_W-1:0] hist, hist_n;
    logic [FILL_W-1:0] fill, fill_n, fill_inc;
    logic [GOOD_W-1:0] good, good_n, good_inc;
    logic [BAD_W-1:0]  bad, bad_n, bad_inc;
    logic              err_n;
    logic              cnt_inc;

    logic [3:0]        pred;
    logic [3:0]        mism;
    logic [2:0]        pop;
    logic [LFSR_W-1:0] ph;
    logic [CNT_W:0]    bit_sum;

    // hist[0] is the most recent serial bit.  Prediction walks forward
    // through predicted bits; the stored history only takes received bits.
    always_comb begin
        ph     = hist;
        pred   = '0;
        hist_n = hist;
        for (int j = 0; j < 4; j++) begin
            pred[3-j] = ^(ph & TAPS);
            ph        = {ph[LFSR_W-2:0], pred[3-j]};
            hist_n    = {hist_n[LFSR_W-2:0], data[3-j]};
        end
        mism = pred ^ data;
        pop  = '0;
        for (int k = 0; k < 4; k++) begin
            pop = pop + {2'b00, mism[k]};
        end
    end

    assign fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign good_inc = good + 1'b1;
    assign bad_inc  = bad + 1'b1;
    assign bit_sum  = {1'b0, bit_err_cnt} + {{(CNT_W-2){1'b0}}, pop};

    always_comb begin
        state_n = state;
        fill_n  = fill;
        good_n  = good;
        bad_n   = bad;
        err_n   = 1'b0;
        cnt_inc = 1'b0;
        if (ready) begin
            unique case (state)
                HUNT: begin
                    fill_n = fill_inc;
                    if (fill_inc == FILL_MAX && |hist_n) begin
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (|mism) begin
                        good_n = '0;
                    end else if (good_inc == GOOD_MAX) begin
                        good_n  = '0;
                        state_n = LOCKED;
                    end else begin
                        good_n = good_inc;
                    end
                end
                LOCKED: begin
                    if (|mism) begin
                        err_n   = 1'b1;
                        cnt_inc = 1'b1;
                        if (bad_inc == BAD_MAX) begin
                            state_n = HUNT;
                            fill_n  = '0;
                            bad_n   = '0;
                            good_n  = '0;
                        end else begin
                            bad_n = bad_inc;
                        end
                    end else begin
                        bad_n = '0;
                    end
                end
                default: begin
                    state_n = HUNT;
                    fill_n  = '0;
                    good_n  = '0;
                    bad_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            good      <= '0;
            bad       <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            fill      <= fill_n;
            good      <= good_n;
            bad       <= bad_n;
            err_pulse <= err_n;
            if (ready) begin
                hist <= hist_n;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_err_cnt <= '0;
            bit_err_cnt  <= '0;
        end else if (clr_cnt) begin
            beat_err_cnt <= '0;
            bit_err_cnt  <= '0;
        end else if (cnt_inc) begin
            if (beat_err_cnt != CNT_MAX) begin
                beat_err_cnt <= beat_err_cnt + 1'b1;
            end
            if (bit_sum[CNT_W]) begin
                bit_err_cnt <= CNT_MAX;
            end else begin
                bit_err_cnt <= bit_sum[CNT_W-1:0];
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_parallel_lfsr_checker.sv
// Directed bench for parallel_lfsr_checker: default instance plus a
// small-counter instance (CNT_W=4, LOSS_BEATS=255) for saturation.
module tb_parallel_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready = 1'b0;
    logic [3:0]  data = 4'h0;
    logic        clr_cnt = 1'b0;

    logic        a_locked, a_err;
    logic [15:0] a_beat, a_bit;
    logic        b_locked, b_err;
    logic [3:0]  b_beat, b_bit;

    int checks = 0;
    int failures = 0;

    logic [6:0] g;
    logic [3:0] nib;
    logic       ep_seen;
    int         rb;
    int         cyc;

    always #5 clk = ~clk;

    parallel_lfsr_checker u_a (
        .clk(clk), .reset_n(reset_n), .ready(ready), .data(data),
        .clr_cnt(clr_cnt), .locked(a_locked), .err_pulse(a_err),
        .beat_err_cnt(a_beat), .bit_err_cnt(a_bit)
    );

    parallel_lfsr_checker #(.LOSS_BEATS(255), .CNT_W(4)) u_b (
        .clk(clk), .reset_n(reset_n), .ready(ready), .data(data),
        .clr_cnt(clr_cnt), .locked(b_locked), .err_pulse(b_err),
        .beat_err_cnt(b_beat), .bit_err_cnt(b_bit)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // PRBS7 x^7+x^6+1 generator, g[0] most recent bit
    task automatic gen_nib(output logic [3:0] n);
        logic b;
        n = '0;
        for (int j = 0; j < 4; j++) begin
            b = g[5] ^ g[6];
            g = {g[5:0], b};
            n = {n[2:0], b};
        end
    endtask

    task automatic beat(input logic r, input logic [3:0] d, input logic c);
        @(negedge clk);
        ready   = r;
        data    = d;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic clean(input int n);
        logic [3:0] x;
        for (int i = 0; i < n; i++) begin
            gen_nib(x);
            beat(1'b1, x, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ready   = 1'b0;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        g = 7'h7F;
    endtask

    initial begin
        g = 7'h7F;
        do_reset();
        #1;
        chk("rst_locked", a_locked, 0);
        chk("rst_err", a_err, 0);
        chk("rst_beat", a_beat, 0);
        chk("rst_bit", a_bit, 0);

        // lock on clean stream: 2 fill + 4 verify
        clean(5);
        chk("nolock_b5", a_locked, 0);
        clean(1);
        chk("lock_b6", a_locked, 1);

        ep_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            clean(1);
            ep_seen |= a_err | ~a_locked;
        end
        chk("clean_no_err", ep_seen, 0);
        chk("clean_beat", a_beat, 0);
        chk("clean_bit", a_bit, 0);

        // single flipped bit, with an idle cycle in between
        gen_nib(nib);
        beat(1'b1, nib ^ 4'h8, 1'b0);
        chk("flip_p1", a_err, 1);
        beat(1'b0, 4'h5, 1'b0);
        chk("idle_no_pulse", a_err, 0);
        chk("idle_beat", a_beat, 1);
        clean(1);
        chk("flip_p2", a_err, 1);
        clean(1);
        chk("flip_p3", a_err, 0);
        chk("flip_beat", a_beat, 2);
        chk("flip_bit", a_bit, 3);
        chk("flip_locked", a_locked, 1);

        gen_nib(nib);
        beat(1'b1, nib, 1'b1);
        chk("clr_beat", a_beat, 0);
        chk("clr_bit", a_bit, 0);
        chk("clr_locked", a_locked, 1);

        // three inverted beats drop lock
        gen_nib(nib);
        beat(1'b1, ~nib, 1'b0);
        chk("inv1_locked", a_locked, 1);
        gen_nib(nib);
        beat(1'b1, ~nib, 1'b0);
        chk("inv2_locked", a_locked, 1);
        gen_nib(nib);
        beat(1'b1, ~nib, 1'b0);
        chk("inv3_locked", a_locked, 0);
        chk("inv3_pulse", a_err, 1);
        chk("inv_beat", a_beat, 3);
        chk("inv_bit", a_bit, 11);
        clean(5);
        chk("relock_b5", a_locked, 0);
        clean(1);
        chk("relock_b6", a_locked, 1);
        chk("relock_beat", a_beat, 3);

        // async reset mid-stream
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_locked", a_locked, 0);
        chk("async_rst_beat", a_beat, 0);
        do_reset();

        // random ready gaps with junk data on idle cycles
        rb = 0;
        cyc = 0;
        ep_seen = 1'b0;
        while (rb < 6 && cyc < 200) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_nib(nib);
                beat(1'b1, nib, 1'b0);
                rb++;
            end else begin
                beat(1'b0, 4'($urandom), 1'b0);
            end
            cyc++;
            if (rb < 6) ep_seen |= a_locked;
            ep_seen |= a_err;
        end
        chk("gap_ready_beats", rb, 6);
        chk("gap_early_lock", ep_seen, 0);
        chk("gap_lock", a_locked, 1);
        chk("gap_beat", a_beat, 0);

        // all-zero data never leaves hunt
        do_reset();
        for (int i = 0; i < 20; i++) beat(1'b1, 4'h0, 1'b0);
        chk("zero_locked", a_locked, 0);
        chk("zero_beat", a_beat, 0);
        chk("zero_bit", a_bit, 0);

        // saturation on the small-counter instance
        do_reset();
        clean(6);
        chk("b_lock", b_locked, 1);
        for (int i = 0; i < 3; i++) begin
            gen_nib(nib);
            beat(1'b1, ~nib, 1'b0);
        end
        chk("b_beat3", b_beat, 3);
        chk("b_bit3", b_bit, 11);
        gen_nib(nib);
        beat(1'b1, ~nib, 1'b0);
        chk("b_bit4", b_bit, 15);
        gen_nib(nib);
        beat(1'b1, ~nib, 1'b0);
        chk("b_bit_clamp", b_bit, 15);
        chk("b_beat5", b_beat, 5);
        for (int i = 0; i < 15; i++) begin
            gen_nib(nib);
            beat(1'b1, ~nib, 1'b0);
        end
        chk("b_beat_sat", b_beat, 15);
        chk("b_bit_sat", b_bit, 15);
        chk("b_still_locked", b_locked, 1);
        gen_nib(nib);
        beat(1'b1, ~nib, 1'b1);
        chk("b_clr_pulse", b_err, 1);
        chk("b_clr_beat", b_beat, 0);
        chk("b_clr_bit", b_bit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
